// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the memory bus arbiter:
//   - address/data/byte-enable widths
//   - FSM state encoding (IDLE, BUS, RESP)
//   - bus owner encoding (OWN_I = instruction fetch, OWN_D = data access)
//   - segment codes taken from va[31:29] for the fixed address map
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WSEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // kseg0 covers 0x8xxx_xxxx/0x9xxx_xxxx, kseg1 covers 0xAxxx_xxxx/0xBxxx_xxxx.
  localparam logic [2:0] SEG_KSEG0 = 3'b100;
  localparam logic [2:0] SEG_KSEG1 = 3'b101;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// External bus master port shared by the two requesters.
//   req    : transaction request, held until ack
//   wr     : write strobe
//   wsel   : byte enables (all zero for reads)
//   addr   : physical address
//   wdata  : write data
//   cached : 1 = cacheable access
//   ack    : one-cycle completion from the bus
//   rdata  : read data, valid with ack
// Modports: master = arbiter side, slave = bus/cache interface side.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [WSEL_W-1:0] wsel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              cached;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, wsel, addr, wdata, cached,
    input  ack, rdata
  );

  modport slave (
    input  req, wr, wsel, addr, wdata, cached,
    output ack, rdata
  );

endinterface

// File: rtl/mem_bus_arbiter_addr_xlate.sv
// addr_xlate
// Purely combinational fixed segment map.
//   va     in  : virtual address
//   pa     out : physical address
//   cached out : 1 = cacheable
// kseg0 strips the top three bits and is cached, kseg1 strips them and is
// uncached, every other segment passes through unchanged and cached.
module addr_xlate
  import mem_bus_arbiter_pkg::*;
(
  input  logic [ADDR_W-1:0] va,
  output logic [ADDR_W-1:0] pa,
  output logic              cached
);

  always_comb begin
    pa     = va;
    cached = 1'b1;
    case (va[ADDR_W-1:ADDR_W-3])
      SEG_KSEG0: begin
        pa = {3'b000, va[ADDR_W-4:0]};
      end
      SEG_KSEG1: begin
        pa     = {3'b000, va[ADDR_W-4:0]};
        cached = 1'b0;
      end
      default: begin
        pa     = va;
        cached = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one external bus master port between instruction fetch and data
// access. The winner's virtual address is translated through the fixed
// segment map and latched together with its payload; the bus side then sees
// stable registered values until bus_ack. The captured read data is handed
// back with a one-cycle ready pulse to the owner only.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   inst_req/addr             : fetch request (always a read)
//   inst_rdata/ready          : fetch response
//   data_req/wr/wsel/addr/wdata : data request
//   data_rdata/ready          : data response
//   bus (master modport)      : external bus port
// Parameter STARVE_LIMIT (1..15): consecutive data grants allowed while a
// fetch is waiting before the fetch is forced through.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [WSEL_W-1:0] data_wsel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  mem_bus_arbiter_if.master bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_reg;
  owner_t            owner_reg;
  logic [3:0]        starve_cnt_reg;
  logic              bus_req_reg;
  logic              bus_wr_reg;
  logic [WSEL_W-1:0] bus_wsel_reg;
  logic [ADDR_W-1:0] bus_addr_reg;
  logic [DATA_W-1:0] bus_wdata_reg;
  logic              bus_cached_reg;
  logic [DATA_W-1:0] inst_rdata_reg;
  logic [DATA_W-1:0] data_rdata_reg;
  logic              inst_ready_reg;
  logic              data_ready_reg;

  // Data wins by default; a waiting fetch is forced once data has been
  // granted LIMIT times in a row while it waited.
  logic              any_req;
  logic              pick_data;
  logic [ADDR_W-1:0] win_va;
  logic [ADDR_W-1:0] win_pa;
  logic              win_cached;

  assign any_req   = inst_req | data_req;
  assign pick_data = data_req & ~(inst_req & (starve_cnt_reg == LIMIT));
  assign win_va    = pick_data ? data_addr : inst_addr;

  addr_xlate u_addr_xlate (
    .va     (win_va),
    .pa     (win_pa),
    .cached (win_cached)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_I;
      starve_cnt_reg <= 4'd0;
      bus_req_reg    <= 1'b0;
      bus_wr_reg     <= 1'b0;
      bus_wsel_reg   <= '0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      bus_cached_reg <= 1'b0;
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
      inst_ready_reg <= 1'b0;
      data_ready_reg <= 1'b0;
    end else begin
      // Ready pulses last exactly one cycle (the RESP cycle).
      inst_ready_reg <= 1'b0;
      data_ready_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            bus_req_reg    <= 1'b1;
            bus_addr_reg   <= win_pa;
            bus_cached_reg <= win_cached;
            if (pick_data) begin
              owner_reg     <= OWN_D;
              bus_wr_reg    <= data_wr;
              bus_wsel_reg  <= data_wr ? data_wsel : '0;
              bus_wdata_reg <= data_wdata;
              starve_cnt_reg <= inst_req ? starve_cnt_reg + 4'd1 : 4'd0;
            end else begin
              owner_reg      <= OWN_I;
              bus_wr_reg     <= 1'b0;
              bus_wsel_reg   <= '0;
              bus_wdata_reg  <= '0;
              starve_cnt_reg <= 4'd0;
            end
            state_reg <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (bus.ack) begin
            bus_req_reg <= 1'b0;
            if (owner_reg == OWN_D) begin
              data_rdata_reg <= bus.rdata;
              data_ready_reg <= 1'b1;
            end else begin
              inst_rdata_reg <= bus.rdata;
              inst_ready_reg <= 1'b1;
            end
            state_reg <= ST_RESP;
          end
        end

        ST_RESP: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req    = bus_req_reg;
  assign bus.wr     = bus_wr_reg;
  assign bus.wsel   = bus_wsel_reg;
  assign bus.addr   = bus_addr_reg;
  assign bus.wdata  = bus_wdata_reg;
  assign bus.cached = bus_cached_reg;

  assign inst_rdata = inst_rdata_reg;
  assign inst_ready = inst_ready_reg;
  assign data_rdata = data_rdata_reg;
  assign data_ready = data_ready_reg;

endmodule
